// File: rtl/id_issue_ctrl_pkg.sv
// Shared ISA constants, FSM state encodings and the ID/EX control bundle type
// for the decode/issue stage.
package id_issue_ctrl_pkg;

    localparam int WORD_SIZE = 16;

    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BGZ   = 4'd2;
    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FN_ADD = 6'd0;
    localparam logic [5:0] FN_SUB = 6'd1;
    localparam logic [5:0] FN_AND = 6'd2;
    localparam logic [5:0] FN_ORR = 6'd3;
    localparam logic [5:0] FN_NOT = 6'd4;
    localparam logic [5:0] FN_TCP = 6'd5;
    localparam logic [5:0] FN_SHL = 6'd6;
    localparam logic [5:0] FN_SHR = 6'd7;
    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_ORR = 3'b011;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JIMM   = 2'b10;
    localparam logic [1:0] PC_JREG   = 2'b11;

    localparam logic [1:0] LINK_REG = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] opcode;
        logic [1:0] rd;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       alu_src_b;
        logic       mem_read;
        logic       mem_write;
        logic       b_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       is_wwd;
        logic       is_hlt;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_decode.sv
// Pure combinational instruction decode: control bundle, source register
// indices and which of them the instruction actually reads.
module id_decode
    import id_issue_ctrl_pkg::*;
(
    input  logic [WORD_SIZE-1:0] inst,
    output ctrl_t                ctrl,
    output logic [1:0]           rs,
    output logic [1:0]           rt,
    output logic                 use_rs,
    output logic                 use_rt
);

    logic [3:0] op;
    logic [5:0] fn;

    assign op = inst[15:12];
    assign fn = inst[5:0];
    assign rs = inst[11:10];
    assign rt = inst[9:8];

    always_comb begin
        ctrl        = CTRL_BUBBLE;
        use_rs      = 1'b0;
        use_rt      = 1'b0;
        ctrl.opcode = op;
        case (op)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
                ctrl.valid  = 1'b1;
                ctrl.b_op   = 1'b1;
                ctrl.pc_src = PC_BRANCH;
                ctrl.alu_op = ALU_SUB;
                use_rs      = 1'b1;
                use_rt      = (op == OP_BNE) || (op == OP_BEQ);
            end
            OP_ADI, OP_ORI, OP_LHI, OP_LWD: begin
                ctrl.valid      = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.rd         = inst[9:8];
                ctrl.alu_src_b  = 1'b1;
                ctrl.alu_op     = (op == OP_ORI) ? ALU_ORR : ALU_ADD;
                ctrl.mem_read   = (op == OP_LWD);
                ctrl.mem_to_reg = (op == OP_LWD);
                use_rs          = 1'b1;
            end
            OP_SWD: begin
                ctrl.valid     = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                use_rs         = 1'b1;
                use_rt         = 1'b1;
            end
            OP_JMP, OP_JAL: begin
                ctrl.valid     = 1'b1;
                ctrl.pc_src    = PC_JIMM;
                ctrl.reg_write = (op == OP_JAL);
                ctrl.rd        = (op == OP_JAL) ? LINK_REG : 2'd0;
            end
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_ORR, FN_NOT, FN_TCP, FN_SHL, FN_SHR: begin
                        ctrl.valid     = 1'b1;
                        ctrl.reg_write = 1'b1;
                        ctrl.rd        = inst[7:6];
                        ctrl.alu_op    = fn[2:0];
                        use_rs         = 1'b1;
                        use_rt         = 1'b1;
                    end
                    FN_JPR, FN_JRL: begin
                        ctrl.valid     = 1'b1;
                        ctrl.pc_src    = PC_JREG;
                        ctrl.reg_write = (fn == FN_JRL);
                        ctrl.rd        = (fn == FN_JRL) ? LINK_REG : 2'd0;
                        use_rs         = 1'b1;
                    end
                    FN_WWD: begin
                        ctrl.valid  = 1'b1;
                        ctrl.is_wwd = 1'b1;
                        use_rs      = 1'b1;
                    end
                    FN_HLT: begin
                        ctrl.valid  = 1'b1;
                        ctrl.is_hlt = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_issue_ctrl.sv
// ID-stage issue control: load-use bubble insertion, mispredict squash,
// HLT parking and the issued-instruction counter.
module id_issue_ctrl
    import id_issue_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] inst_in,
    input  logic                 valid_in,
    input  logic [1:0]           ex_rd,
    input  logic                 ex_MemRead,
    input  logic                 ex_RegWrite,
    input  logic                 ex_mispredict,
    output logic                 stall_if,
    output logic                 flush_if,
    output logic                 issue_valid,
    output logic [3:0]           opcode_out,
    output logic [1:0]           rd_out,
    output logic [1:0]           PCSrc_out,
    output logic [2:0]           ALUOp_out,
    output logic                 ALUSrcB_out,
    output logic                 MemRead_out,
    output logic                 MemWrite_out,
    output logic                 B_OP_out,
    output logic                 RegWrite_out,
    output logic                 MemtoReg_out,
    output logic                 is_wwd_out,
    output logic                 halted,
    output logic [CNT_W-1:0]     num_inst
);

    ctrl_t      dec_ctrl;
    ctrl_t      ctrl_out;
    logic [1:0] dec_rs;
    logic [1:0] dec_rt;
    logic       dec_use_rs;
    logic       dec_use_rt;
    logic       lu_hazard;
    logic       issue_ok;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] num_inst_reg;

    id_decode u_decode (
        .inst   (inst_in),
        .ctrl   (dec_ctrl),
        .rs     (dec_rs),
        .rt     (dec_rt),
        .use_rs (dec_use_rs),
        .use_rt (dec_use_rt)
    );

    assign lu_hazard = valid_in && ex_MemRead && ex_RegWrite &&
                       ((dec_use_rs && (dec_rs == ex_rd)) || (dec_use_rt && (dec_rt == ex_rd)));
    assign issue_ok  = valid_in && dec_ctrl.valid;

    // Mispredict outranks everything: the IF/ID word is wrong-path, so it is
    // never held and never issued, even if it would have caused a stall.
    always_comb begin
        ctrl_out   = CTRL_BUBBLE;
        stall_if   = 1'b0;
        flush_if   = 1'b0;
        halted     = 1'b0;
        state_next = state_reg;
        if (reset) begin
            state_next = ST_RUN;
        end else if (ex_mispredict) begin
            flush_if   = 1'b1;
            state_next = ST_RUN;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (lu_hazard) begin
                        stall_if   = 1'b1;
                        state_next = ST_LU_STALL;
                    end else if (issue_ok) begin
                        ctrl_out   = dec_ctrl;
                        state_next = dec_ctrl.is_hlt ? ST_HALT : ST_RUN;
                    end
                end
                ST_LU_STALL: begin
                    state_next = ST_RUN;
                    if (issue_ok) begin
                        ctrl_out   = dec_ctrl;
                        state_next = dec_ctrl.is_hlt ? ST_HALT : ST_RUN;
                    end
                end
                ST_HALT: begin
                    stall_if = 1'b1;
                    halted   = 1'b1;
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_RUN;
            num_inst_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (ctrl_out.valid) begin
                num_inst_reg <= num_inst_reg + CNT_W'(1);
            end
        end
    end

    assign issue_valid  = ctrl_out.valid;
    assign opcode_out   = ctrl_out.opcode;
    assign rd_out       = ctrl_out.rd;
    assign PCSrc_out    = ctrl_out.pc_src;
    assign ALUOp_out    = ctrl_out.alu_op;
    assign ALUSrcB_out  = ctrl_out.alu_src_b;
    assign MemRead_out  = ctrl_out.mem_read;
    assign MemWrite_out = ctrl_out.mem_write;
    assign B_OP_out     = ctrl_out.b_op;
    assign RegWrite_out = ctrl_out.reg_write;
    assign MemtoReg_out = ctrl_out.mem_to_reg;
    assign is_wwd_out   = ctrl_out.is_wwd;
    assign num_inst     = num_inst_reg;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Bench for id_issue_ctrl: instruction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_id_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] inst_in = '0;
    logic        valid_in = 1'b0;
    logic [1:0]  ex_rd = '0;
    logic        ex_MemRead = 1'b0;
    logic        ex_RegWrite = 1'b0;
    logic        ex_mispredict = 1'b0;

    logic        stall_if, flush_if, issue_valid;
    logic [3:0]  opcode_out;
    logic [1:0]  rd_out, PCSrc_out;
    logic [2:0]  ALUOp_out;
    logic        ALUSrcB_out, MemRead_out, MemWrite_out, B_OP_out;
    logic        RegWrite_out, MemtoReg_out, is_wwd_out, halted;
    logic [15:0] num_inst;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_issue_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .inst_in(inst_in), .valid_in(valid_in),
        .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite),
        .ex_mispredict(ex_mispredict), .stall_if(stall_if), .flush_if(flush_if),
        .issue_valid(issue_valid), .opcode_out(opcode_out), .rd_out(rd_out),
        .PCSrc_out(PCSrc_out), .ALUOp_out(ALUOp_out), .ALUSrcB_out(ALUSrcB_out),
        .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out), .B_OP_out(B_OP_out),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .is_wwd_out(is_wwd_out), .halted(halted), .num_inst(num_inst)
    );

    // ---------------- instruction-set reference ----------------
    function automatic bit is_defined(input logic [15:0] i);
        logic [3:0] op;
        logic [5:0] fn;
        op = i[15:12];
        fn = i[5:0];
        if (op <= 4'd10) return 1'b1;
        if (op == 4'd15 && (fn <= 6'd7 || fn == 6'd25 || fn == 6'd26 || fn == 6'd28 || fn == 6'd29))
            return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_hlt(input logic [15:0] i);
        return i[15:12] == 4'd15 && i[5:0] == 6'd29;
    endfunction

    function automatic bit reads_reg(input logic [15:0] i, input logic [1:0] r);
        logic [3:0] op;
        logic [5:0] fn;
        bit rs_used, rt_used;
        op = i[15:12];
        fn = i[5:0];
        rs_used = is_defined(i) && !(op == 4'd9 || op == 4'd10 || is_hlt(i));
        rt_used = (op == 4'd15 && fn <= 6'd7) || op == 4'd0 || op == 4'd1 || op == 4'd8;
        return (rs_used && i[11:10] == r) || (rt_used && i[9:8] == r);
    endfunction

    // {issue, opcode, rd, pcsrc, aluop, alusrcb, memread, memwrite, b_op, regwrite, memtoreg, wwd}
    function automatic logic [18:0] payload(input logic [15:0] i);
        logic [3:0] op;
        logic [5:0] fn;
        bit r, jpr, jrl, imm_w;
        logic [1:0] rd, pc;
        logic [2:0] alu;
        op    = i[15:12];
        fn    = i[5:0];
        r     = (op == 4'd15) && fn <= 6'd7;
        jpr   = (op == 4'd15) && fn == 6'd25;
        jrl   = (op == 4'd15) && fn == 6'd26;
        imm_w = op >= 4'd4 && op <= 4'd7;
        rd    = r ? i[7:6] : imm_w ? i[9:8] : (op == 4'd10 || jrl) ? 2'd2 : 2'd0;
        pc    = (op <= 4'd3) ? 2'd1 : (op == 4'd9 || op == 4'd10) ? 2'd2 : (jpr || jrl) ? 2'd3 : 2'd0;
        alu   = r ? fn[2:0] : (op == 4'd5) ? 3'd3 : (op <= 4'd3) ? 3'd1 : 3'd0;
        return {1'b1, op, rd, pc, alu,
                (op >= 4'd4 && op <= 4'd8), (op == 4'd7), (op == 4'd8), (op <= 4'd3),
                (r || imm_w || op == 4'd10 || jrl), (op == 4'd7),
                (op == 4'd15 && fn == 6'd28)};
    endfunction

    // ---------------- pipeline-level model ----------------
    bit          m_known = 1'b0;
    bit          m_halt  = 1'b0;
    bit          m_owed  = 1'b0;   // a bubble was already paid for the held instruction
    int          m_cnt   = 0;
    bit          e_stall, e_flush, e_halted, e_hazard, e_hlt_issue;
    logic [18:0] e_payload;

    task automatic compute_expect();
        e_stall = 0; e_flush = 0; e_halted = 0; e_hazard = 0; e_hlt_issue = 0;
        e_payload = '0;
        if (reset) begin
        end else if (ex_mispredict) begin
            e_flush = 1;
        end else if (m_halt) begin
            e_stall  = 1;
            e_halted = 1;
        end else begin
            e_hazard = valid_in && !m_owed && ex_MemRead && ex_RegWrite && reads_reg(inst_in, ex_rd);
            if (e_hazard) e_stall = 1;
            else if (valid_in && is_defined(inst_in)) begin
                e_payload   = payload(inst_in);
                e_hlt_issue = is_hlt(inst_in);
            end
        end
    endtask

    always @(negedge clk) begin
        logic [21:0] exp_v, act_v;
        compute_expect();
        exp_v = {e_stall, e_flush, e_payload, e_halted};
        act_v = {stall_if, flush_if, issue_valid, opcode_out, rd_out, PCSrc_out, ALUOp_out,
                 ALUSrcB_out, MemRead_out, MemWrite_out, B_OP_out, RegWrite_out,
                 MemtoReg_out, is_wwd_out, halted};
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL bundle @%0t: got %h want %h (inst=%h)", $time, act_v, exp_v, inst_in);
        end
        if (m_known) begin
            total++;
            if (num_inst !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL num_inst @%0t: got %0d want %0d", $time, num_inst, m_cnt);
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            m_known = 1; m_halt = 0; m_owed = 0; m_cnt = 0;
        end else if (ex_mispredict) begin
            m_halt = 0; m_owed = 0;
        end else if (!m_halt) begin
            m_owed = e_hazard;
            if (e_payload[18]) m_cnt = (m_cnt + 1) % 65536;
            if (e_hlt_issue) m_halt = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] i, input logic v, input logic [1:0] rd,
                         input logic mr, input logic rw, input logic mp, input logic rst);
        @(posedge clk);
        #1;
        inst_in = i; valid_in = v; ex_rd = rd; ex_MemRead = mr;
        ex_RegWrite = rw; ex_mispredict = mp; reset = rst;
    endtask

    localparam logic [15:0] ADD_123  = 16'hFB40;  // ADD $1,$2,$3
    localparam logic [15:0] ADD_RS1  = 16'hF6C0;  // ADD $3,$1,$2
    localparam logic [15:0] JMP_I    = 16'h90FF;
    localparam logic [15:0] HLT_I    = 16'hF01D;

    initial begin
        logic [5:0] fn_pick [12];
        fn_pick = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd25, 6'd26, 6'd28, 6'd29};

        drive(16'h0, 0, 0, 0, 0, 0, 1);
        drive(16'h0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("reset_num_inst", 32'(num_inst), 0);
        chk("reset_issue", 32'(issue_valid), 0);
        chk("reset_pcsrc", 32'(PCSrc_out), 0);

        drive(ADD_123, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("add_issue", 32'(issue_valid), 1);
        chk("add_regwrite", 32'(RegWrite_out), 1);
        chk("add_rd", 32'(rd_out), 1);

        drive(ADD_RS1, 1, 1, 1, 1, 0, 0);
        @(negedge clk);
        chk("add_counted", 32'(num_inst), 1);
        chk("lu_stall", 32'(stall_if), 1);
        chk("lu_bubble", 32'(issue_valid), 0);
        drive(ADD_RS1, 1, 1, 1, 1, 0, 0);
        @(negedge clk);
        chk("lu_release_stall", 32'(stall_if), 0);
        chk("lu_release_issue", 32'(issue_valid), 1);

        drive(JMP_I, 1, 1, 1, 1, 0, 0);
        @(negedge clk);
        chk("lu_count_once", 32'(num_inst), 2);
        chk("jmp_nostall", 32'(stall_if), 0);
        chk("jmp_pcsrc", 32'(PCSrc_out), 2);

        drive(ADD_RS1, 1, 1, 1, 1, 1, 0);
        @(negedge clk);
        chk("mp_flush", 32'(flush_if), 1);
        chk("mp_nostall", 32'(stall_if), 0);
        chk("mp_bubble", 32'(issue_valid), 0);
        drive(ADD_RS1, 1, 1, 1, 1, 0, 0);
        @(negedge clk);
        chk("mp_back_to_run", 32'(stall_if), 1);
        drive(ADD_RS1, 1, 1, 1, 1, 0, 0);

        drive(HLT_I, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("hlt_issue", 32'(issue_valid), 1);
        for (int k = 0; k < 2; k++) begin
            drive(ADD_123, 1, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk("halted", 32'(halted), 1);
            chk("halt_stall", 32'(stall_if), 1);
        end
        drive(ADD_123, 1, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("unhalt_halted", 32'(halted), 0);
        chk("unhalt_flush", 32'(flush_if), 1);
        drive(ADD_123, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_unhalt_issue", 32'(issue_valid), 1);
        chk("post_unhalt_count", 32'(num_inst), 5);

        for (int n = 0; n < 3000; n++) begin
            logic [15:0] ri;
            ri = 16'($urandom);
            if (ri[15:12] == 4'd15) ri[5:0] = fn_pick[$urandom_range(0, 11)];
            drive(ri, ($urandom_range(0, 7) != 0), 2'($urandom), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 199) == 0));
        end

        drive(16'h0, 0, 0, 0, 0, 0, 1);
        repeat (65535) drive(ADD_123, 1, 0, 0, 0, 0, 0);
        drive(16'h0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("count_max", 32'(num_inst), 32'hFFFF);
        drive(ADD_123, 1, 0, 0, 0, 0, 0);
        drive(16'h0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("count_wrap", 32'(num_inst), 0);

        drive(ADD_123, 1, 0, 0, 0, 0, 0);
        drive(ADD_RS1, 1, 1, 1, 1, 0, 0);
        @(negedge clk);
        chk("pre_rst_stall", 32'(stall_if), 1);
        drive(ADD_RS1, 1, 1, 1, 1, 0, 1);
        @(negedge clk);
        chk("rst_mid_bubble", 32'(issue_valid), 0);
        drive(ADD_RS1, 1, 1, 1, 1, 0, 0);
        @(negedge clk);
        chk("rst_mid_count", 32'(num_inst), 0);
        chk("rst_mid_run", 32'(stall_if), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
